// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit with iterative 1-bit-per-cycle shifter.
// Ports: clk/rst, in_valid/in_ready + ALUctrl/src_a/src_b,
//        out_valid/out_ready + result/zero, busy.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;

   localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

   state_t             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;

   logic [SHAMT_W-1:0] shamt;
   logic               is_shift;
   logic               accept;
   logic [WIDTH-1:0]   alu_res;

   // One-bit shift step of the iterative shifter.
   function automatic logic [WIDTH-1:0] step(
      input logic [3:0]       op,
      input logic [WIDTH-1:0] v
   );
      logic [WIDTH-1:0] r;
      r = v;
      if (op == OP_SLL)
         r = {v[WIDTH-2:0], 1'b0};
      else if (op == OP_SRL)
         r = {1'b0, v[WIDTH-1:1]};
      else if (op == OP_SRA)
         r = {v[WIDTH-1], v[WIDTH-1:1]};
      return r;
   endfunction

   assign shamt    = src_b[SHAMT_W-1:0];
   assign is_shift = (ALUctrl == OP_SLL) ||
                     (ALUctrl == OP_SRL) ||
                     (ALUctrl == OP_SRA);
   assign in_ready = (state_q == IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   // Single-cycle ops; shift codes pass src_a through (shamt 0 case).
   always_comb begin
      alu_res = '0;
      case (ALUctrl)
         OP_ADD:  alu_res = src_a + src_b;
         OP_SUB:  alu_res = src_a - src_b;
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_XOR:  alu_res = src_a ^ src_b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  alu_res = src_a;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                             $signed(src_a) < $signed(src_b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}},
                             src_a < src_b};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_shift && shamt != '0) begin
                  // First shift step happens on the accept
                  // edge, so out_valid arrives shamt cycles
                  // after accept.
                  op_d  = ALUctrl;
                  acc_d = step(ALUctrl, src_a);
                  cnt_d = shamt - CNT_ONE;
                  if (shamt == CNT_ONE) begin
                     result_d = acc_d;
                     zero_d   = (acc_d == '0);
                     state_d  = DONE;
                  end else begin
                     state_d  = SHIFT;
                  end
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  state_d  = DONE;
               end
            end
         end
         SHIFT: begin
            acc_d = step(op_q, acc_q);
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               result_d = acc_d;
               zero_d   = (acc_d == '0);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule
